// File: rtl/buzzer_pkg.sv
// Shared definitions for the alarm buzzer path: one-hot FSM states and
// cycle-count helpers derived from the clock frequency.
package buzzer_pkg;

  typedef enum logic [4:0] {
    ST_IDLE     = 5'b00001,
    ST_BEEP_ON  = 5'b00010,
    ST_BEEP_OFF = 5'b00100,
    ST_GAP      = 5'b01000,
    ST_MUTED    = 5'b10000
  } state_t;

  function automatic int half_cycles(input int clk_hz, input int tone_hz);
    return clk_hz / (2 * tone_hz);
  endfunction

  function automatic int ms_cycles(input int clk_hz);
    return clk_hz / 1000;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..MS-1 and pulses tick on the last count.
// clr holds the count at zero so a restarted period is a full millisecond.
module ms_tick_gen
  import buzzer_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset_p,
  input  logic clr,
  output logic tick
);

  localparam int MS = ms_cycles(CLK_HZ);
  localparam int W  = (MS > 1) ? $clog2(MS) : 1;

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == W'(MS - 1));
  assign tick   = w_last & ~clr;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_cnt <= '0;
    end else if (clr || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alarm_buzzer_seq.sv
// Turns the cook-timer alarm level into a gated piezo tone with beep/burst
// cadence, user mute and auto-mute timeout. alarm high at edge N -> buz from N+1.
module alarm_buzzer_seq
  import buzzer_pkg::*;
#(
  parameter int CLK_HZ          = 100_000_000,
  parameter int TONE_HZ         = 2000,
  parameter int BEEP_ON_MS      = 200,
  parameter int BEEP_OFF_MS     = 200,
  parameter int BEEPS_PER_BURST = 4,
  parameter int BURST_GAP_MS    = 1000,
  parameter int TIMEOUT_MS      = 60000
) (
  input  logic clk,
  input  logic reset_p,
  input  logic enable,
  input  logic alarm,
  input  logic mute,
  output logic buz,
  output logic led_beep,
  output logic active
);

  localparam int HALF   = half_cycles(CLK_HZ, TONE_HZ);
  localparam int HALF_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int PH_MAX = max3(BEEP_ON_MS, BEEP_OFF_MS, BURST_GAP_MS);
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int BEEP_W = $clog2(BEEPS_PER_BURST + 1);
  localparam int TO_W   = $clog2(TIMEOUT_MS + 1);

  state_t            r_state;
  logic [HALF_W-1:0] r_half_cnt;
  logic              r_tone;
  logic [PH_W-1:0]   r_ph_cnt;
  logic [BEEP_W-1:0] r_beep_cnt;
  logic [TO_W-1:0]   r_to_cnt;

  logic w_active;
  logic w_tick;
  logic w_ph_last;
  logic w_ph_done;
  logic w_timeout;
  logic w_last_beep;

  assign w_active = (r_state == ST_BEEP_ON) || (r_state == ST_BEEP_OFF) || (r_state == ST_GAP);

  // Phase changes always land on a tick, where the prescaler wraps anyway, so
  // holding it clear outside the sounding states makes every phase exact.
  ms_tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_ms_tick (
    .clk    (clk),
    .reset_p(reset_p),
    .clr    (~w_active),
    .tick   (w_tick)
  );

  always_comb begin
    w_ph_last = 1'b0;
    case (r_state)
      ST_BEEP_ON:  w_ph_last = (r_ph_cnt == PH_W'(BEEP_ON_MS - 1));
      ST_BEEP_OFF: w_ph_last = (r_ph_cnt == PH_W'(BEEP_OFF_MS - 1));
      ST_GAP:      w_ph_last = (r_ph_cnt == PH_W'(BURST_GAP_MS - 1));
      default:     w_ph_last = 1'b0;
    endcase
  end

  assign w_ph_done   = w_tick & w_ph_last;
  assign w_timeout   = w_tick & (r_to_cnt == TO_W'(TIMEOUT_MS - 1));
  assign w_last_beep = (r_beep_cnt == BEEP_W'(BEEPS_PER_BURST - 1));

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_state    <= ST_IDLE;
      r_half_cnt <= '0;
      r_tone     <= 1'b1;
      r_ph_cnt   <= '0;
      r_beep_cnt <= '0;
      r_to_cnt   <= '0;
    end else begin
      // Tone restarts high at every beep because it is parked outside BEEP_ON.
      if (r_state == ST_BEEP_ON) begin
        if (r_half_cnt == HALF_W'(HALF - 1)) begin
          r_half_cnt <= '0;
          r_tone     <= ~r_tone;
        end else begin
          r_half_cnt <= r_half_cnt + 1'b1;
        end
      end else begin
        r_half_cnt <= '0;
        r_tone     <= 1'b1;
      end

      if (!w_active) begin
        r_ph_cnt <= '0;
      end else if (w_tick) begin
        r_ph_cnt <= w_ph_last ? '0 : r_ph_cnt + 1'b1;
      end

      if (r_state == ST_IDLE) begin
        r_beep_cnt <= '0;
      end else if (r_state == ST_BEEP_ON && w_ph_done) begin
        r_beep_cnt <= w_last_beep ? '0 : r_beep_cnt + 1'b1;
      end

      if (r_state == ST_IDLE) begin
        r_to_cnt <= '0;
      end else if (w_active && w_tick && r_to_cnt != TO_W'(TIMEOUT_MS)) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end

      if (!enable) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (alarm) r_state <= mute ? ST_MUTED : ST_BEEP_ON;
          end
          ST_BEEP_ON, ST_BEEP_OFF, ST_GAP: begin
            if (!alarm) begin
              r_state <= ST_IDLE;
            end else if (mute || w_timeout) begin
              r_state <= ST_MUTED;
            end else if (w_ph_done) begin
              if (r_state == ST_BEEP_ON) r_state <= w_last_beep ? ST_GAP : ST_BEEP_OFF;
              else                       r_state <= ST_BEEP_ON;
            end
          end
          ST_MUTED: begin
            if (!alarm) r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign buz      = (r_state == ST_BEEP_ON) & r_tone;
  assign led_beep = (r_state == ST_BEEP_ON);
  assign active   = w_active;

endmodule

// File: tb/tb_alarm_buzzer_seq.sv
// Directed bench for alarm_buzzer_seq at MS=10, HALF=5: cadence, alarm drop,
// mute, timeout, simultaneous events, enable and asynchronous reset.
module tb_alarm_buzzer_seq;

  logic clk = 1'b0;
  logic reset_p;
  logic enable;
  logic alarm;
  logic mute;
  logic buz;
  logic led_beep;
  logic active;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alarm_buzzer_seq #(
    .CLK_HZ         (10000),
    .TONE_HZ        (1000),
    .BEEP_ON_MS     (2),
    .BEEP_OFF_MS    (2),
    .BEEPS_PER_BURST(2),
    .BURST_GAP_MS   (4),
    .TIMEOUT_MS     (25)
  ) dut (
    .clk     (clk),
    .reset_p (reset_p),
    .enable  (enable),
    .alarm   (alarm),
    .mute    (mute),
    .buz     (buz),
    .led_beep(led_beep),
    .active  (active)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs == exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Cycle c counts from 1 = first cycle after the edge that sampled alarm.
  // Period: ON 1-20, OFF 21-40, ON 41-60, GAP 61-100.
  function automatic logic exp_on(input int c);
    int p;
    p = (c - 1) % 100;
    return (p < 20) || (p >= 40 && p < 60);
  endfunction

  function automatic logic exp_buz(input int c);
    int p;
    int q;
    p = (c - 1) % 100;
    q = (p < 20) ? p : p - 40;
    return exp_on(c) && ((q / 5) % 2 == 0);
  endfunction

  task automatic chk_cycle(input string pfx, input int c);
    chk($sformatf("%s_buz_c%0d", pfx, c), buz, exp_buz(c));
    chk($sformatf("%s_led_c%0d", pfx, c), led_beep, exp_on(c));
    chk($sformatf("%s_act_c%0d", pfx, c), active, 1'b1);
  endtask

  task automatic go_idle();
    alarm  = 1'b0;
    mute   = 1'b0;
    enable = 1'b1;
    step(2);
  endtask

  initial begin
    logic seen_buz;
    logic seen_act;
    int   act_cnt;

    reset_p = 1'b1;
    enable  = 1'b1;
    alarm   = 1'b1;
    mute    = 1'b0;
    #2;
    chk("rst_buz", buz, 1'b0);
    chk("rst_led", led_beep, 1'b0);
    chk("rst_act", active, 1'b0);
    step(2);
    chk("rst_hold_buz", buz, 1'b0);
    chk("rst_hold_act", active, 1'b0);
    alarm   = 1'b0;
    reset_p = 1'b0;
    step(2);
    chk("post_rst_act", active, 1'b0);

    // Full burst cadence through the gap into the next burst.
    alarm = 1'b1;
    for (int c = 1; c <= 101; c++) begin
      step(1);
      chk_cycle("cad", c);
    end
    go_idle();

    // Alarm dropped mid-beep.
    alarm = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      step(1);
      chk_cycle("drop", c);
    end
    alarm = 1'b0;
    step(1);
    chk("drop_buz", buz, 1'b0);
    chk("drop_act", active, 1'b0);
    chk("drop_led", led_beep, 1'b0);
    step(3);
    chk("drop_idle_act", active, 1'b0);

    // Mute during BEEP_OFF, hold alarm, then re-arm.
    alarm = 1'b1;
    step(30);
    chk("mute_pre_act", active, 1'b1);
    chk("mute_pre_buz", buz, 1'b0);
    mute = 1'b1;
    step(1);
    mute = 1'b0;
    chk("mute_buz", buz, 1'b0);
    chk("mute_act", active, 1'b0);
    seen_buz = 1'b0;
    seen_act = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      seen_buz |= buz;
      seen_act |= active;
    end
    chk("muted_no_buz", seen_buz, 1'b0);
    chk("muted_no_act", seen_act, 1'b0);
    alarm = 1'b0;
    step(1);
    alarm = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step(1);
      chk_cycle("rearm", c);
    end
    go_idle();

    // Auto-mute after 25 ms of sounding.
    alarm   = 1'b1;
    act_cnt = 0;
    for (int c = 1; c <= 260; c++) begin
      step(1);
      if (active) act_cnt++;
      if (c == 250) chk("to_act_c250", active, 1'b1);
      if (c == 251) chk("to_act_c251", active, 1'b0);
    end
    chk_int("to_active_cycles", act_cnt, 250);
    seen_buz = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      seen_buz |= buz;
    end
    chk("to_silent", seen_buz, 1'b0);
    go_idle();

    // Alarm rise and mute together: mute wins.
    alarm = 1'b1;
    mute  = 1'b1;
    step(1);
    mute     = 1'b0;
    seen_buz = 1'b0;
    seen_act = 1'b0;
    for (int i = 0; i < 30; i++) begin
      seen_buz |= buz;
      seen_act |= active;
      step(1);
    end
    chk("simul_no_buz", seen_buz, 1'b0);
    chk("simul_no_act", seen_act, 1'b0);
    go_idle();

    // enable=0 during BEEP_ON, then re-enable with alarm still high.
    alarm = 1'b1;
    step(3);
    chk("en_pre_buz", buz, 1'b1);
    enable = 1'b0;
    step(1);
    chk("en_off_buz", buz, 1'b0);
    chk("en_off_act", active, 1'b0);
    chk("en_off_led", led_beep, 1'b0);
    enable = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step(1);
      chk_cycle("reen", c);
    end
    go_idle();

    // Asynchronous reset between edges mid-beep.
    alarm = 1'b1;
    step(2);
    chk("arst_pre_buz", buz, 1'b1);
    #3;
    reset_p = 1'b1;
    #1;
    chk("arst_buz", buz, 1'b0);
    chk("arst_led", led_beep, 1'b0);
    chk("arst_act", active, 1'b0);
    step(1);
    reset_p = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      step(1);
      chk_cycle("arst", c);
    end
    go_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alarm_buzzer_seq.md
Name: alarm_buzzer_seq

Overview:
- Downstream stage of the cook-timer path. Consumes the level `alarm` from cook_timer and drives the piezo `buz` pin and an LED.
- Produces a square-wave tone gated into a beep/burst cadence.
- Supports user mute and an automatic timeout, so the board does not beep indefinitely.
- Replaces the direct `buz = alarm` connection in the multifunction top.

Parameters:
- CLK_HZ, 100_000_000: input clock frequency.
- TONE_HZ, 2000: buzzer tone frequency.
- BEEP_ON_MS, 200: tone-on time per beep.
- BEEP_OFF_MS, 200: silence between beeps inside a burst.
- BEEPS_PER_BURST, 4: beeps per burst.
- BURST_GAP_MS, 1000: silence after the last beep of a burst.
- TIMEOUT_MS, 60000: total sounding time before auto-mute.

Ports:
- clk  in  1  system clock
- reset_p  in  1  asynchronous, active-high reset
- enable  in  1  block enable; 0 forces IDLE
- alarm  in  1  level from cook_timer; 1 = time expired
- mute  in  1  single-cycle pulse (debounced button pedge); silences the current alarm
- buz  out  1  tone output to the piezo
- led_beep  out  1  high while in BEEP_ON
- active  out  1  high in BEEP_ON, BEEP_OFF or GAP

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - reset_p asynchronously forces state=IDLE, tone=1, all counters=0.
  - buz=0, led_beep=0, active=0 during and after reset.
  - Reset mid-beep: buz drops immediately.
- Derived constants (integer division):
  - HALF = CLK_HZ/(2*TONE_HZ) cycles.
  - MS = CLK_HZ/1000 cycles.
- ms tick prescaler:
  - Counts 0..MS-1 and pulses `tick` on MS-1.
  - Cleared on every state entry, so each state's duration is exact.
- States: IDLE, BEEP_ON, BEEP_OFF, GAP, MUTED. Encoding is one-hot, 5 bits.
- IDLE:
  - alarm=1 & enable=1 & mute=0 -> BEEP_ON next clock, with beep_cnt=0 and timeout_cnt=0.
  - alarm=1 & mute=1 in the same cycle -> MUTED (mute wins).
- BEEP_ON:
  - After BEEP_ON_MS ticks, beep_cnt increments.
  - If the new beep_cnt is BEEPS_PER_BURST, beep_cnt resets to 0 and the next state is GAP.
  - Otherwise the next state is BEEP_OFF.
- BEEP_OFF: after BEEP_OFF_MS ticks -> BEEP_ON.
- GAP: after BURST_GAP_MS ticks -> BEEP_ON.
- Any of BEEP_ON, BEEP_OFF, GAP:
  - alarm=0 -> IDLE next clock. alarm=0 takes priority over mute and timeout.
  - mute=1 -> MUTED.
  - timeout_cnt reaching TIMEOUT_MS -> MUTED.
- MUTED: held while alarm=1; alarm=0 -> IDLE. A new alarm therefore needs alarm to drop first.
- enable=0 in any state -> IDLE next clock. This has top priority after reset.
- timeout_cnt:
  - Counts ticks while active=1 and is not cleared between burst phases.
  - Width is clog2(TIMEOUT_MS+1) and it saturates.
- Tone:
  - Half-period counter 0..HALF-1; tone toggles at HALF-1.
  - On entry to BEEP_ON, the counter is cleared and tone=1, so the first half-period of every beep is high.
- Outputs:
  - buz = BEEP_ON & tone (registered state/tone, combinational AND).
  - led_beep = BEEP_ON.
  - active = BEEP_ON | BEEP_OFF | GAP.
- Latency: alarm sampled high at edge N -> buz=1 from edge N+1.
- mute pulses while alarm=0 are ignored.

Decomposition:
- Shared package (buzzer_pkg):
  - State localparams: ST_IDLE=5'b00001, ST_BEEP_ON, ST_BEEP_OFF, ST_GAP, ST_MUTED.
  - Derived-constant function for HALF and MS.
- One sub-module: ms_tick_gen (params CLK_HZ; ports clk, reset_p, clr, tick).
  - Reusable later by watch and cook_timer rework.

Test Plan (CLK_HZ=10000, TONE_HZ=1000, BEEP_ON_MS=2, BEEP_OFF_MS=2, BEEPS_PER_BURST=2, BURST_GAP_MS=4; so MS=10 and HALF=5):
- Burst cadence: raise alarm at cycle 0 ->
  - buz pattern 1×5, 0×5, 1×5, 0×5 on cycles 1–20;
  - silent on cycles 21–40;
  - tone again on cycles 41–60;
  - silent on cycles 61–100 (GAP);
  - next BEEP_ON at cycle 101; active=1 throughout.
- Alarm drop: drop alarm at cycle 13 -> buz=0, active=0 from cycle 14; state IDLE.
- Mute: mute pulse at cycle 30 (alarm=1) -> MUTED, buz=0 and active=0 from cycle 31. Alarm stays 1 for 200 cycles with no tone. Alarm 0 then 1 again -> beeping restarts with the first-beep pattern.
- Timeout with TIMEOUT_MS=25, alarm held high -> MUTED after 250 cycles of activity; buz stays 0 while alarm remains 1.
- Simultaneous events:
  - alarm rise and mute in the same cycle -> MUTED, buz never toggles.
  - enable=0 during BEEP_ON -> IDLE next clock.
- Reset: assert reset_p asynchronously mid-BEEP_ON (between clock edges) -> buz, led_beep and active go 0 immediately. After release with alarm=1 -> beep cadence restarts from cycle 1 of the pattern.
